gpio_pixel_packer: RTL and testbench
====================================

// Module: gpio_pixel_packer
// PURPOSE
//  Downstream consumer of the processor GPIO output stream. Captures 32-bit channel words
//  (4 packed 8-bit samples) tagged by GPIOEnR/GPIOEnG/GPIOEnB and regroups them into pixel-
//  interleaved bytes (R,G,B per pixel) on a valid/ready byte stream toward the host link.
//  Ping-pong double buffering absorbs processor output, which has no backpressure.
// PARAMETERS
//  FRAME_WORDS  40000  complete R/G/B word groups per frame; sets out_last/frame_done
//  CNT_W        16     width of group counter grp_cnt (must hold FRAME_WORDS-1)
// PORTS
//  clk         in   1      system clock, all state on rising edge
//  rst         in   1      asynchronous, active-low reset
//  GPIO        in   32     channel word; byte k = sample of pixel k (k=0..3, byte0=[7:0])
//  GPIOEnR     in   1      GPIO holds the red word this cycle
//  GPIOEnG     in   1      GPIO holds the green word this cycle
//  GPIOEnB     in   1      GPIO holds the blue word this cycle
//  out_ready   in   1      sink accepts out_data this cycle
//  clr_err     in   1      synchronous clear of sticky error flags
//  out_data    out  8      output byte
//  out_valid   out  1      out_data valid
//  out_last    out  1      with out_valid: final byte of the frame
//  frame_done  out  1      one-cycle pulse when final byte of frame is accepted
//  ovf_err     out  1      sticky: word dropped, target slot unavailable
//  en_err      out  1      sticky: more than one enable high in the same cycle
//  busy        out  1      any bank holds data or emission in progress
//  grp_cnt     out  CNT_W  groups fully emitted in current frame
// BEHAVIOUR
//  Reset (rst=0, async): all outputs 0, both banks empty, fill bank=0, emitter IDLE, grp_cnt=0.
//  Banks: 2 x {R,G,B} 32-bit slots with per-slot full flags; fill pointer selects capture bank.
//  Capture: exactly one enable high -> word written to that channel slot of fill bank, flag set.
//   Channel order within a group is free. Slot already full, or fill bank complete and other
//   bank not free -> word dropped, ovf_err=1. Two or three enables high -> nothing captured,
//   en_err=1 (ovf_err not set). No enable -> no change.
//  Bank complete when all 3 flags set; on that edge fill pointer flips to other bank if it is
//   empty, otherwise stays (further words overflow until a bank frees).
//  Emitter FSM: IDLE -> EMIT when a complete bank exists (oldest first); EMIT holds byte idx
//   0..11; pixel p=idx/3, channel c=idx%3 (0=R,1=G,2=B); out_data=slot[c][8p+7:8p].
//  Latency: out_valid rises the cycle after the edge that captured the completing word.
//  Handshake: transfer on out_valid&out_ready; out_data/out_last stable while valid&!ready;
//   valid never drops without a transfer.
//  On transfer of idx 11: bank flags cleared (bank free same edge, fill may flip to it);
//   grp_cnt+1; if other bank complete, next cycle shows its idx 0 (no bubble), else IDLE.
//  Capture into a bank freed on the same edge is permitted (free takes priority).
//  Frame: out_last=1 on idx 11 when grp_cnt==FRAME_WORDS-1; its transfer pulses frame_done
//   and wraps grp_cnt to 0.
//  clr_err clears ovf_err/en_err; an error event in the same cycle wins (flag stays 1).
//  busy = any bank flag set or FSM in EMIT.
// TESTING
//  1 R=04030201,G=14131211,B=24232221, ready=1 -> 01,11,21,02,12,22,03,13,23,04,14,24;
//    out_valid one cycle after B capture, 12 consecutive transfers, grp_cnt=1.
//  2 Same stimulus, out_ready toggling 1/0 -> identical byte sequence, out_data held when stalled.
//  3 Group A then group B with ready=0, then ready=1 -> 24 bytes A then B, no bubble;
//    third group's R while both banks full -> dropped, ovf_err=1, emitted bytes unaffected.
//  4 GPIOEnR=GPIOEnG=1 same cycle -> en_err=1, busy stays 0; clr_err -> en_err=0.
//  5 FRAME_WORDS=2, two groups -> out_last only on byte 24, frame_done 1 cycle, grp_cnt=0.
//  6 rst=0 mid-emit (idx 5) -> all outputs 0 immediately; after release new group emits from idx 0.

Source files
------------

// File: rtl/gpio_pixel_packer.sv
// Regroups R/G/B channel words from the GPIO stream into pixel-interleaved bytes.
// Two capture banks ping-pong so a bank can fill while the other one drains.
module gpio_pixel_packer #(
  parameter int unsigned FRAME_WORDS = 40000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      GPIO,
  input  logic             GPIOEnR,
  input  logic             GPIOEnG,
  input  logic             GPIOEnB,
  input  logic             out_ready,
  input  logic             clr_err,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             out_last,
  output logic             frame_done,
  output logic             ovf_err,
  output logic             en_err,
  output logic             busy,
  output logic [CNT_W-1:0] grp_cnt
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t      state, state_n;
  logic        ebank, ebank_n;
  logic        fill, fill_n;
  logic [1:0]  pix, pix_n, ch, ch_n;
  logic [31:0] slot [2][3];
  logic [2:0]  full [2];
  logic [2:0]  eff [2];
  logic [2:0]  full_n [2];
  logic [2:0]  en;
  logic [1:0]  cap_ch;
  logic        one_en, multi_en, cap_bank, blocked, cap_ok, drop;
  logic        xfer, last_byte, freeing;
  logic [31:0] word;

  assign en = {GPIOEnB, GPIOEnG, GPIOEnR};

  // Capture path works on post-free flags so a bank released this edge is writable now.
  always_comb begin
    xfer      = (state == EMIT) && out_ready;
    last_byte = (pix == 2'd3) && (ch == 2'd2);
    freeing   = xfer && last_byte;
    eff[0]    = full[0] & {3{!(freeing && !ebank)}};
    eff[1]    = full[1] & {3{!(freeing && ebank)}};
    one_en    = (en == 3'b001) || (en == 3'b010) || (en == 3'b100);
    multi_en  = (en != 3'b000) && !one_en;
    cap_ch    = en[2] ? 2'd2 : (en[1] ? 2'd1 : 2'd0);
    cap_bank  = fill;
    blocked   = 1'b0;
    if (&eff[fill]) begin
      cap_bank = !fill;
      blocked  = |eff[!fill];
    end
    cap_ok    = one_en && !blocked && !eff[cap_bank][cap_ch];
    drop      = one_en && !cap_ok;
    full_n[0] = eff[0];
    full_n[1] = eff[1];
    if (cap_ok) full_n[cap_bank][cap_ch] = 1'b1;
    fill_n = fill;
    if (cap_ok && (cap_bank != fill))
      fill_n = !fill;
    else if ((&full_n[fill]) && !(|full_n[!fill]))
      fill_n = !fill;
  end

  // Next-state logic also looks at post-edge flags, giving one-cycle capture-to-valid latency.
  always_comb begin
    state_n = state;
    ebank_n = ebank;
    pix_n   = pix;
    ch_n    = ch;
    case (state)
      IDLE: begin
        pix_n = 2'd0;
        ch_n  = 2'd0;
        if (&full_n[!fill]) begin
          state_n = EMIT;
          ebank_n = !fill;
        end else if (&full_n[fill]) begin
          state_n = EMIT;
          ebank_n = fill;
        end
      end
      EMIT: begin
        if (xfer) begin
          if (last_byte) begin
            pix_n = 2'd0;
            ch_n  = 2'd0;
            if (&full_n[!ebank]) ebank_n = !ebank;
            else                 state_n = IDLE;
          end else if (ch == 2'd2) begin
            ch_n  = 2'd0;
            pix_n = pix + 2'd1;
          end else begin
            ch_n  = ch + 2'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    case (ch)
      2'd0:    word = slot[ebank][0];
      2'd1:    word = slot[ebank][1];
      default: word = slot[ebank][2];
    endcase
    out_valid  = (state == EMIT);
    out_data   = out_valid ? word[{pix, 3'b000} +: 8] : '0;
    out_last   = out_valid && last_byte && (grp_cnt == CNT_W'(FRAME_WORDS - 1));
    frame_done = out_last && out_ready;
    busy       = (|full[0]) || (|full[1]) || out_valid;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ebank   <= 1'b0;
      pix     <= 2'd0;
      ch      <= 2'd0;
      fill    <= 1'b0;
      full[0] <= '0;
      full[1] <= '0;
      grp_cnt <= '0;
      ovf_err <= 1'b0;
      en_err  <= 1'b0;
    end else begin
      state   <= state_n;
      ebank   <= ebank_n;
      pix     <= pix_n;
      ch      <= ch_n;
      fill    <= fill_n;
      full[0] <= full_n[0];
      full[1] <= full_n[1];
      if (freeing) grp_cnt <= out_last ? '0 : grp_cnt + 1'b1;
      ovf_err <= drop     || (ovf_err && !clr_err);
      en_err  <= multi_en || (en_err  && !clr_err);
    end
  end

  always_ff @(posedge clk) begin
    if (cap_ok) slot[cap_bank][cap_ch] <= GPIO;
  end

endmodule

// File: tb/tb_gpio_pixel_packer.sv
// Scoreboard bench for gpio_pixel_packer: stimulus pushes expected bytes, a monitor pops them.
module tb_gpio_pixel_packer;

  localparam int unsigned FW = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] GPIO = '0;
  logic        GPIOEnR = 1'b0, GPIOEnG = 1'b0, GPIOEnB = 1'b0;
  logic        out_ready = 1'b0, clr_err = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid, out_last, frame_done, ovf_err, en_err, busy;
  logic [15:0] grp_cnt;

  gpio_pixel_packer #(.FRAME_WORDS(FW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .GPIO(GPIO),
    .GPIOEnR(GPIOEnR), .GPIOEnG(GPIOEnG), .GPIOEnB(GPIOEnB),
    .out_ready(out_ready), .clr_err(clr_err),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .frame_done(frame_done), .ovf_err(ovf_err), .en_err(en_err),
    .busy(busy), .grp_cnt(grp_cnt)
  );

  always #5 clk = ~clk;

  logic [8:0] exp_q [$];
  int compared   = 0;
  int mismatched = 0;
  int fd_count   = 0;
  int model_grp  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted byte is compared against the head of the scoreboard.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_byte: got %0h with last=%0b, nothing expected", out_data, out_last);
      end else begin
        e = exp_q.pop_front();
        check("byte_last_data", 32'({out_last, out_data}), 32'(e));
      end
    end
    if (frame_done) begin
      fd_count++;
      check("frame_done_qual", 32'({out_valid, out_ready, out_last}), 32'h7);
    end
  end

  task automatic push_group(input logic [31:0] r, input logic [31:0] g, input logic [31:0] b);
    logic [31:0] w;
    logic        last;
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 3; c++) begin
        w    = (c == 0) ? r : ((c == 1) ? g : b);
        last = (p == 3) && (c == 2) && (model_grp == FW - 1);
        exp_q.push_back({last, w[8*p +: 8]});
      end
    end
    model_grp = (model_grp + 1) % FW;
  endtask

  task automatic drive(input logic [2:0] en3, input logic [31:0] data);
    GPIO = data;
    {GPIOEnB, GPIOEnG, GPIOEnR} = en3;
    @(posedge clk); #1;
    {GPIOEnB, GPIOEnG, GPIOEnR} = 3'b000;
  endtask

  task automatic send_group(input logic [31:0] r, input logic [31:0] g, input logic [31:0] b,
                            input bit rev);
    push_group(r, g, b);
    if (!rev) begin
      drive(3'b001, r); drive(3'b010, g); drive(3'b100, b);
    end else begin
      drive(3'b100, b); drive(3'b010, g); drive(3'b001, r);
    end
  endtask

  task automatic wait_idle(input int maxc, output int n);
    n = 0;
    while (busy && n < maxc) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  logic [7:0] t1 [12] = '{8'h01, 8'h11, 8'h21, 8'h02, 8'h12, 8'h22,
                          8'h03, 8'h13, 8'h23, 8'h04, 8'h14, 8'h24};

  initial begin
    int         n;
    logic       pv, pr;
    logic [7:0] pd;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", 32'({out_valid, out_last, frame_done, ovf_err, en_err, busy}), 32'h0);
    check("reset_data", 32'(out_data), 32'h0);
    check("reset_grp_cnt", 32'(grp_cnt), 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: single group, sink always ready
    out_ready = 1'b1;
    foreach (t1[i]) exp_q.push_back({1'b0, t1[i]});
    model_grp = 1;
    drive(3'b001, 32'h04030201);
    drive(3'b010, 32'h14131211);
    drive(3'b100, 32'h24232221);
    check("t1_latency_valid", 32'(out_valid), 32'h1);
    check("t1_first_byte", 32'(out_data), 32'h01);
    wait_idle(40, n);
    check("t1_emit_cycles", 32'(n), 32'd12);
    check("t1_grp_cnt", 32'(grp_cnt), 32'd1);
    check("t1_no_frame_done", 32'(fd_count), 32'd0);

    // 2: same group, stalls; this group closes the two-group frame
    out_ready = 1'b0;
    send_group(32'h04030201, 32'h14131211, 32'h24232221, 1'b0);
    check("t2_stalled_valid", 32'(out_valid), 32'h1);
    check("t2_stalled_data", 32'(out_data), 32'h01);
    for (int i = 0; i < 40 && busy; i++) begin
      out_ready = (i % 2 == 0);
      pv = out_valid; pr = out_ready; pd = out_data;
      @(posedge clk); #1;
      if (pv && !pr) begin
        check("t2_hold_valid", 32'(out_valid), 32'h1);
        check("t2_hold_data", 32'(out_data), 32'(pd));
      end
    end
    check("t2_drained", 32'(busy), 32'h0);
    check("t2_grp_cnt_wrap", 32'(grp_cnt), 32'd0);
    check("t2_frame_done_count", 32'(fd_count), 32'd1);

    // 3: both banks fill while stalled; third group's R overflows
    out_ready = 1'b0;
    send_group(32'hA3A2A1A0, 32'hB3B2B1B0, 32'hC3C2C1C0, 1'b0);
    send_group(32'h3F2E1D0C, 32'h7B6A5948, 32'hF7E6D5C4, 1'b0);
    drive(3'b001, 32'hDEADBEEF);
    check("t3_ovf_set", 32'(ovf_err), 32'h1);
    check("t3_en_err_clear", 32'(en_err), 32'h0);
    check("t3_queue_depth", 32'(exp_q.size()), 32'd24);
    out_ready = 1'b1;
    wait_idle(60, n);
    check("t3_emit_cycles", 32'(n), 32'd24);
    check("t3_grp_cnt", 32'(grp_cnt), 32'd0);
    check("t3_frame_done_count", 32'(fd_count), 32'd2);
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    check("t3_ovf_cleared", 32'(ovf_err), 32'h0);

    // 4: multiple enables
    drive(3'b011, 32'h12345678);
    check("t4_en_err_set", 32'(en_err), 32'h1);
    check("t4_ovf_untouched", 32'(ovf_err), 32'h0);
    check("t4_busy_idle", 32'(busy), 32'h0);
    clr_err = 1'b1;
    drive(3'b101, 32'h0);
    check("t4_error_beats_clear", 32'(en_err), 32'h1);
    @(posedge clk); #1;
    clr_err = 1'b0;
    check("t4_en_err_cleared", 32'(en_err), 32'h0);

    // 6: reset mid-emit at idx 5, then a reverse-order group
    out_ready = 1'b0;
    send_group(32'h11111111, 32'h22222222, 32'h33333333, 1'b0);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("t6_pre_reset_left", 32'(exp_q.size()), 32'd7);
    rst = 1'b0;
    out_ready = 1'b0;
    #1;
    check("t6_async_outs", 32'({out_valid, out_last, frame_done, ovf_err, en_err, busy}), 32'h0);
    check("t6_async_data", 32'(out_data), 32'h0);
    exp_q.delete();
    model_grp = 0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_group(32'h4D3C2B1A, 32'h8E7F6A5B, 32'hC9B8A796, 1'b1);
    wait_idle(40, n);
    check("t6_emit_cycles", 32'(n), 32'd12);
    check("t6_grp_cnt", 32'(grp_cnt), 32'd1);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
